// File: rtl/amo_sequencer_if.sv
// Data-bus port bundle between the atomic sequencer (master) and the memory side (slave).
// Bus outputs are registered in the master and held until an ack.
interface amo_sequencer_if #(
  parameter int XLEN = 32
);
  logic            o_bus_req;
  logic            o_bus_we;
  logic [XLEN-1:0] o_bus_addr;
  logic [XLEN-1:0] o_bus_wdata;
  logic            i_bus_ack;
  logic [XLEN-1:0] i_bus_rdata;
  logic            i_bus_err;

  modport master (
    output o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata,
    input  i_bus_ack, i_bus_rdata, i_bus_err
  );

  modport slave (
    input  o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata,
    output i_bus_ack, i_bus_rdata, i_bus_err
  );
endinterface

// File: rtl/amo_sequencer.sv
// RISC-V A-extension sequencer: runs LR.W / SC.W / AMO*.W as read-modify-write bus
// transactions and owns the single LR/SC reservation.
module atomic_alu #(
  parameter int XLEN = 32
) (
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] s1,
  input  logic [XLEN-1:0] s2,
  output logic [XLEN-1:0] result
);
  always_comb begin
    result = s1;
    case (op)
      5'b00000: result = s1 + s2;
      5'b00001: result = s1;
      5'b00100: result = s1 ^ s2;
      5'b01000: result = s1 | s2;
      5'b01100: result = s1 & s2;
      5'b10000: result = ($signed(s1) < $signed(s2)) ? s1 : s2;
      5'b10100: result = ($signed(s1) > $signed(s2)) ? s1 : s2;
      5'b11000: result = (s1 < s2) ? s1 : s2;
      5'b11100: result = (s1 > s2) ? s1 : s2;
      default:  result = s1;
    endcase
  end
endmodule

// state  | meaning
// IDLE   | waiting for i_start
// READ   | read request outstanding (LR or AMO load)
// WRITE  | write request outstanding (SC or AMO store)
// DONE   | transaction finished, completion pulse follows
module amo_sequencer #(
  parameter int XLEN          = 32,
  parameter int RSV_GRAN_LOG2 = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic [4:0]          i_op,
  input  logic [XLEN-1:0]     i_addr,
  input  logic [XLEN-1:0]     i_rs2,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err,
  output logic [XLEN-1:0]     o_rd,
  amo_sequencer_if.master     bus,
  input  logic                i_inval,
  input  logic [XLEN-1:0]     i_inval_addr
);
  localparam int GW = XLEN - RSV_GRAN_LOG2;
  localparam logic [4:0] OP_LR = 5'b00010;
  localparam logic [4:0] OP_SC = 5'b00011;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  state_t          state, state_next;
  logic [4:0]      op_q;
  logic [XLEN-1:0] rs2_q;
  logic            err_q;
  logic            busy_q;
  logic            rsv_valid;
  logic [GW-1:0]   rsv_gran;

  logic            accept, op_legal, misaligned, is_lr, is_sc, gran_hit;
  logic            rd_ack, wr_ack, inval_hit, inval_on_lr, lr_set, rsv_clear;
  logic [XLEN-1:0] alu_result;
  logic            unused_inval_lsb;

  assign unused_inval_lsb = ^i_inval_addr[RSV_GRAN_LOG2-1:0];

  atomic_alu #(.XLEN(XLEN)) u_alu (
    .op     (op_q),
    .s1     (rs2_q),
    .s2     (bus.i_bus_rdata),
    .result (alu_result)
  );

  always_comb begin
    op_legal = 1'b0;
    case (i_op)
      5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b01000,
      5'b01100, 5'b10000, 5'b10100, 5'b11000, 5'b11100: op_legal = 1'b1;
      default: op_legal = 1'b0;
    endcase
  end

  assign o_busy      = busy_q;
  // busy_q also covers the o_done cycle, so acceptance waits one more cycle
  assign accept      = (state == S_IDLE) && !busy_q && i_start;
  assign misaligned  = |i_addr[1:0];
  assign is_lr       = (i_op == OP_LR);
  assign is_sc       = (i_op == OP_SC);
  assign gran_hit    = rsv_valid && (rsv_gran == i_addr[XLEN-1:RSV_GRAN_LOG2]);
  assign rd_ack      = (state == S_READ) && bus.i_bus_ack;
  assign wr_ack      = (state == S_WRITE) && bus.i_bus_ack;
  assign inval_hit   = i_inval && rsv_valid && (i_inval_addr[XLEN-1:RSV_GRAN_LOG2] == rsv_gran);
  assign inval_on_lr = i_inval &&
                       (i_inval_addr[XLEN-1:RSV_GRAN_LOG2] == bus.o_bus_addr[XLEN-1:RSV_GRAN_LOG2]);
  assign lr_set      = rd_ack && !bus.i_bus_err && (op_q == OP_LR);
  assign rsv_clear   = (accept && is_sc) ||
                       (accept && op_legal && !misaligned && !is_lr && gran_hit) ||
                       ((rd_ack || wr_ack) && bus.i_bus_err) ||
                       inval_hit;

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (!op_legal || misaligned) state_next = S_DONE;
          else if (is_sc)              state_next = gran_hit ? S_WRITE : S_DONE;
          else                         state_next = S_READ;
        end
      end
      S_READ: begin
        if (bus.i_bus_ack)
          state_next = (bus.i_bus_err || op_q == OP_LR) ? S_DONE : S_WRITE;
      end
      S_WRITE: if (bus.i_bus_ack) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q            <= '0;
      rs2_q           <= '0;
      err_q           <= 1'b0;
      busy_q          <= 1'b0;
      o_done          <= 1'b0;
      o_err           <= 1'b0;
      o_rd            <= '0;
      bus.o_bus_req   <= 1'b0;
      bus.o_bus_we    <= 1'b0;
      bus.o_bus_addr  <= '0;
      bus.o_bus_wdata <= '0;
      rsv_valid       <= 1'b0;
      rsv_gran        <= '0;
    end else begin
      o_done <= (state == S_DONE);
      o_err  <= (state == S_DONE) && err_q;
      busy_q <= (state_next != S_IDLE) || (state == S_DONE);

      if (accept) begin
        op_q           <= i_op;
        rs2_q          <= i_rs2;
        bus.o_bus_addr <= i_addr;
        err_q          <= !op_legal || misaligned;
        if (state_next == S_READ) begin
          bus.o_bus_req <= 1'b1;
          bus.o_bus_we  <= 1'b0;
        end else if (state_next == S_WRITE) begin
          bus.o_bus_req   <= 1'b1;
          bus.o_bus_we    <= 1'b1;
          bus.o_bus_wdata <= i_rs2;
        end
        if (op_legal && !misaligned && is_sc && !gran_hit) o_rd <= {{(XLEN-1){1'b0}}, 1'b1};
      end

      if (rd_ack) begin
        if (bus.i_bus_err) begin
          err_q         <= 1'b1;
          bus.o_bus_req <= 1'b0;
        end else if (op_q == OP_LR) begin
          o_rd          <= bus.i_bus_rdata;
          bus.o_bus_req <= 1'b0;
        end else begin
          o_rd            <= bus.i_bus_rdata;
          bus.o_bus_we    <= 1'b1;
          bus.o_bus_wdata <= alu_result;
        end
      end

      if (wr_ack) begin
        bus.o_bus_req <= 1'b0;
        bus.o_bus_we  <= 1'b0;
        if (bus.i_bus_err)       err_q <= 1'b1;
        else if (op_q == OP_SC)  o_rd  <= '0;
      end

      // a same-granule store seen during the LR ack beats the new reservation
      if (lr_set) begin
        rsv_valid <= !inval_on_lr;
        rsv_gran  <= bus.o_bus_addr[XLEN-1:RSV_GRAN_LOG2];
      end else if (rsv_clear) begin
        rsv_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_amo_sequencer.sv
// Directed bench for amo_sequencer: memory-backed bus responder plus a transaction-level
// model of LR/SC/AMO outcomes, latency and reservation state.
module tb_amo_sequencer;
  localparam logic [4:0] OP_ADD  = 5'b00000, OP_SWAP = 5'b00001, OP_LR   = 5'b00010,
                         OP_SC   = 5'b00011, OP_XOR  = 5'b00100, OP_OR   = 5'b01000,
                         OP_AND  = 5'b01100, OP_MIN  = 5'b10000, OP_MAX  = 5'b10100,
                         OP_MINU = 5'b11000, OP_MAXU = 5'b11100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic [4:0]  i_op = '0;
  logic [31:0] i_addr = '0, i_rs2 = '0;
  logic        o_busy, o_done, o_err;
  logic [31:0] o_rd;
  logic        i_inval = 1'b0;
  logic [31:0] i_inval_addr = '0;

  always #5 clk = ~clk;

  amo_sequencer_if #(.XLEN(32)) bus ();

  amo_sequencer #(.XLEN(32), .RSV_GRAN_LOG2(2)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_op(i_op), .i_addr(i_addr),
    .i_rs2(i_rs2), .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_rd(o_rd),
    .bus(bus), .i_inval(i_inval), .i_inval_addr(i_inval_addr)
  );

  int tests = 0, fails = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  logic [31:0] mem [logic [31:0]];
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] amo_fn(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SWAP: return a;
      OP_XOR:  return a ^ b;
      OP_OR:   return a | b;
      OP_AND:  return a & b;
      OP_MIN:  return ($signed(a) < $signed(b)) ? a : b;
      OP_MAX:  return ($signed(a) > $signed(b)) ? a : b;
      OP_MINU: return (a < b) ? a : b;
      OP_MAXU: return (a > b) ? a : b;
      default: return 32'h0;
    endcase
  endfunction

  // bus responder / invalidation driver
  int          wait_cfg = 0;
  bit          err_read = 0, coinc = 0, stray_ack = 0, inval_pend = 0;
  logic [31:0] inval_pa = '0, last_wdata = '0;
  int          n_reads = 0, n_writes = 0, req_cycles = 0;

  initial begin
    int wcnt;
    wcnt = 0;
    bus.i_bus_ack = 1'b0; bus.i_bus_err = 1'b0; bus.i_bus_rdata = '0;
    forever begin
      @(negedge clk);
      bus.i_bus_ack = 1'b0; bus.i_bus_err = 1'b0; bus.i_bus_rdata = '0; i_inval = 1'b0;
      if (inval_pend) begin
        i_inval = 1'b1; i_inval_addr = inval_pa; inval_pend = 0;
      end
      if (stray_ack) begin
        bus.i_bus_ack = 1'b1; bus.i_bus_rdata = 32'hDEAD_BEEF; stray_ack = 0;
      end else if (rst_n && bus.o_bus_req) begin
        req_cycles++;
        if (wcnt >= wait_cfg) begin
          wcnt = 0;
          bus.i_bus_ack = 1'b1;
          if (bus.o_bus_we) begin
            n_writes++;
            last_wdata = bus.o_bus_wdata;
            mem[bus.o_bus_addr] = bus.o_bus_wdata;
          end else begin
            n_reads++;
            bus.i_bus_err = err_read;
            bus.i_bus_rdata = mem_rd(bus.o_bus_addr);
            if (coinc) begin
              i_inval = 1'b1; i_inval_addr = bus.o_bus_addr;
            end
          end
        end else wcnt++;
      end else wcnt = 0;
    end
  end

  // transaction model state and expectations
  bit          m_rv = 0;
  logic [29:0] m_rg = '0;
  bit          armed = 0, done_seen = 0;
  logic        exp_err = 0, exp_rd_valid = 0;
  logic [31:0] exp_rd = '0, exp_wdata = '0, exp_addr = '0, last_rd = '0;
  int          exp_nr = 0, exp_nw = 0, exp_lat = 0, start_cyc = 0, last_lat = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (armed) begin
        chk("busy_during_op", 32'(o_busy), 32'd1);
        if (bus.o_bus_req) chk("bus_addr", bus.o_bus_addr, exp_addr);
        if (o_done) begin
          last_lat = cyc - start_cyc;
          last_rd  = o_rd;
          chk("latency", 32'(last_lat), 32'(exp_lat));
          chk("err", 32'(o_err), 32'(exp_err));
          if (exp_rd_valid) chk("rd", o_rd, exp_rd);
          chk("bus_reads", 32'(n_reads), 32'(exp_nr));
          chk("bus_writes", 32'(n_writes), 32'(exp_nw));
          if (exp_nw > 0) chk("wdata", last_wdata, exp_wdata);
          armed = 0;
          done_seen = 1;
        end
      end
    end
  end

  task automatic do_op(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] rs2,
                       input int w, input bit rerr, input bit poke);
    bit legal, mis, hit;
    logic [31:0] old;
    legal = op inside {OP_ADD, OP_SWAP, OP_LR, OP_SC, OP_XOR, OP_OR, OP_AND,
                       OP_MIN, OP_MAX, OP_MINU, OP_MAXU};
    mis = (addr[1:0] != 2'b00);
    old = mem_rd(addr);
    exp_err = 0; exp_rd_valid = 0; exp_rd = '0; exp_nr = 0; exp_nw = 0;
    exp_wdata = '0; exp_addr = addr;
    if (!legal || mis) begin
      exp_err = 1; exp_lat = 1;
      if (op == OP_SC) m_rv = 0;
    end else if (op == OP_LR) begin
      exp_nr = 1; exp_lat = 2 + w;
      if (rerr) begin exp_err = 1; m_rv = 0; end
      else begin exp_rd_valid = 1; exp_rd = old; m_rv = !coinc; m_rg = addr[31:2]; end
    end else if (op == OP_SC) begin
      hit = m_rv && (m_rg == addr[31:2]);
      m_rv = 0; exp_rd_valid = 1;
      if (hit) begin exp_nw = 1; exp_wdata = rs2; exp_rd = 32'd0; exp_lat = 2 + w; end
      else begin exp_rd = 32'd1; exp_lat = 1; end
    end else begin
      if (m_rv && m_rg == addr[31:2]) m_rv = 0;
      exp_nr = 1;
      if (rerr) begin exp_err = 1; exp_lat = 2 + w; m_rv = 0; end
      else begin
        exp_rd_valid = 1; exp_rd = old; exp_nw = 1;
        exp_wdata = amo_fn(op, rs2, old); exp_lat = 3 + 2 * w;
      end
    end
    wait_cfg = w; err_read = rerr; n_reads = 0; n_writes = 0; req_cycles = 0;
    @(negedge clk);
    chk("idle_before_start", 32'(o_busy), 32'd0);
    i_start = 1'b1; i_op = op; i_addr = addr; i_rs2 = rs2;
    @(posedge clk); #1;
    start_cyc = cyc; done_seen = 0; armed = 1; i_start = 1'b0;
    if (poke) begin
      @(negedge clk);
      i_start = 1'b1; i_op = OP_ADD; i_addr = 32'h8;
      @(negedge clk);
      i_start = 1'b0;
    end
    for (int k = 0; k < 300 && !done_seen; k++) @(negedge clk);
    if (!done_seen) begin
      tests++; fails++; armed = 0;
      $display("FAIL timeout: no o_done for op %b addr 0x%08h", op, addr);
    end
    err_read = 0;
  endtask

  task automatic inval(input logic [31:0] a);
    if (m_rv && m_rg == a[31:2]) m_rv = 0;
    inval_pa = a; inval_pend = 1;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",  32'(o_busy), 32'd0);
    chk("rst_done",  32'(o_done), 32'd0);
    chk("rst_err",   32'(o_err), 32'd0);
    chk("rst_req",   32'(bus.o_bus_req), 32'd0);
    chk("rst_we",    32'(bus.o_bus_we), 32'd0);
    chk("rst_rd",    o_rd, 32'd0);
    chk("rst_addr",  bus.o_bus_addr, 32'd0);
    chk("rst_wdata", bus.o_bus_wdata, 32'd0);
    rst_n = 1'b1;

    mem[32'h40] = 32'h7FFF_FFFF;
    do_op(OP_ADD, 32'h40, 32'd1, 0, 0, 0);
    chk("amoadd_mem_lit", mem_rd(32'h40), 32'h8000_0000);
    chk("amoadd_rd_lit", last_rd, 32'h7FFF_FFFF);
    chk("amoadd_lat_lit", 32'(last_lat), 32'd3);

    mem[32'h44] = 32'hFFFF_FFFF;
    do_op(OP_MIN, 32'h44, 32'd5, 0, 0, 0);
    chk("amomin_mem_lit", mem_rd(32'h44), 32'hFFFF_FFFF);
    chk("amomin_rd_lit", last_rd, 32'hFFFF_FFFF);
    mem[32'h48] = 32'hFFFF_FFFF;
    do_op(OP_MINU, 32'h48, 32'd5, 0, 0, 0);
    chk("amominu_mem_lit", mem_rd(32'h48), 32'd5);
    chk("amominu_rd_lit", last_rd, 32'hFFFF_FFFF);

    mem[32'h100] = 32'h1234;
    do_op(OP_LR, 32'h100, 32'd0, 0, 0, 0);
    chk("lr_lat_lit", 32'(last_lat), 32'd2);
    do_op(OP_SC, 32'h100, 32'hAB, 0, 0, 0);
    chk("sc_mem_lit", mem_rd(32'h100), 32'hAB);
    chk("sc_rd_lit", last_rd, 32'd0);
    do_op(OP_SC, 32'h100, 32'hCD, 0, 0, 0);
    chk("sc2_rd_lit", last_rd, 32'd1);
    chk("sc2_lat_lit", 32'(last_lat), 32'd1);
    chk("sc2_noreq", 32'(req_cycles), 32'd0);

    do_op(OP_LR, 32'h100, 32'd0, 0, 0, 0);
    inval(32'h102);
    do_op(OP_SC, 32'h100, 32'h55, 0, 0, 0);
    chk("inval_hit_sc_lit", last_rd, 32'd1);
    do_op(OP_LR, 32'h100, 32'd0, 0, 0, 0);
    inval(32'h104);
    do_op(OP_SC, 32'h100, 32'h66, 0, 0, 0);
    chk("inval_other_sc_lit", last_rd, 32'd0);

    mem[32'h60] = 32'h0F0F_00FF;
    do_op(OP_XOR, 32'h60, 32'hFF00_FF00, 1, 0, 1);
    do_op(OP_OR, 32'h60, 32'h0000_0F00, 1, 0, 0);
    do_op(OP_AND, 32'h60, 32'hFFFF_0000, 2, 0, 0);
    mem[32'h64] = 32'h8000_0000;
    do_op(OP_MAX, 32'h64, 32'd3, 0, 0, 0);
    chk("amomax_mem_lit", mem_rd(32'h64), 32'd3);
    mem[32'h68] = 32'h8000_0000;
    do_op(OP_MAXU, 32'h68, 32'd3, 1, 0, 0);
    chk("amomaxu_mem_lit", mem_rd(32'h68), 32'h8000_0000);
    do_op(OP_SWAP, 32'h68, 32'h1357_9BDF, 0, 0, 0);

    do_op(OP_LR, 32'h200, 32'd0, 0, 0, 0);
    do_op(OP_ADD, 32'h300, 32'd7, 2, 1, 0);
    chk("buserr_lat_lit", 32'(last_lat), 32'd4);
    do_op(OP_SC, 32'h200, 32'h77, 0, 0, 0);
    chk("buserr_rsv_cleared_lit", last_rd, 32'd1);

    do_op(OP_ADD, 32'h101, 32'd1, 0, 0, 0);
    chk("misalign_lat_lit", 32'(last_lat), 32'd1);
    chk("misalign_noreq", 32'(req_cycles), 32'd0);
    do_op(5'b00101, 32'h40, 32'd1, 0, 0, 0);
    chk("illegal_noreq", 32'(req_cycles), 32'd0);

    do_op(OP_LR, 32'h180, 32'd0, 0, 0, 0);
    do_op(OP_OR, 32'h180, 32'h10, 0, 0, 0);
    do_op(OP_SC, 32'h180, 32'h99, 0, 0, 0);

    coinc = 1;
    do_op(OP_LR, 32'h1C0, 32'd0, 0, 0, 0);
    coinc = 0;
    do_op(OP_SC, 32'h1C0, 32'h11, 0, 0, 0);
    chk("coinc_inval_lit", last_rd, 32'd1);
    do_op(OP_LR, 32'h1C0, 32'd0, 3, 0, 0);
    do_op(OP_SC, 32'h1C0, 32'h22, 2, 0, 0);

    // reset while the AMO store is waiting for its ack
    mem[32'h50] = 32'h10;
    wait_cfg = 20;
    @(negedge clk);
    i_start = 1'b1; i_op = OP_ADD; i_addr = 32'h50; i_rs2 = 32'd1;
    @(posedge clk); #1;
    i_start = 1'b0;
    for (int k = 0; k < 100 && !bus.o_bus_we; k++) @(negedge clk);
    if (!bus.o_bus_we) begin
      tests++; fails++;
      $display("FAIL reset_setup: write phase never reached, got we=%0d required 1", bus.o_bus_we);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_req", 32'(bus.o_bus_req), 32'd0);
    chk("midrst_busy", 32'(o_busy), 32'd0);
    chk("midrst_we", 32'(bus.o_bus_we), 32'd0);
    m_rv = 0;
    @(negedge clk);
    rst_n = 1'b1;
    stray_ack = 1;
    repeat (3) begin
      @(negedge clk);
      chk("late_ack_busy", 32'(o_busy), 32'd0);
      chk("late_ack_req", 32'(bus.o_bus_req), 32'd0);
    end
    chk("late_ack_mem", mem_rd(32'h50), 32'h10);
    do_op(OP_ADD, 32'h50, 32'd1, 0, 0, 0);
    chk("post_rst_mem_lit", mem_rd(32'h50), 32'h11);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/amo_sequencer.md
# amo_sequencer

Sequencing stage for RISC-V "A" extension instructions (LR.W, SC.W, AMO*.W). It sits between the execute stage and the data bus, and runs each atomic as a read / modify / write transaction. The modify step is done by the team's combinational `atomic_alu`, instantiated internally. The block also owns the single LR/SC reservation register.

## Interface
- `RSV_GRAN_LOG2`, default 2: log2 of the reservation granule in bytes. Address bits above this index are compared for reservation match.
- `XLEN` comes from the shared defines; it is 32 in this configuration.

- `clk`  in  1  clock. There is exactly one clock domain.
- `rst_n`  in  1  reset, synchronous and active-low.
- `i_start`  in  1  request a new atomic. Sampled only in IDLE.
- `i_op`  in  5  funct5 encoding:
  - AMOADD 00000, AMOSWAP 00001, LR 00010, SC 00011
  - AMOXOR 00100, AMOOR 01000, AMOAND 01100
  - AMOMIN 10000, AMOMAX 10100, AMOMINU 11000, AMOMAXU 11100
- `i_addr`  in  XLEN  effective address (rs1).
- `i_rs2`  in  XLEN  source operand.
- `o_busy`  out  1  high whenever state is not IDLE.
- `o_done`  out  1  one-cycle completion pulse.
- `o_err`  out  1  qualifies `o_done`: the access faulted.
- `o_rd`  out  XLEN  writeback value. Valid with `o_done`; held until the next `o_done`.
- `o_bus_req`  out  1  bus request.
- `o_bus_we`  out  1  1 = write.
- `o_bus_addr`  out  XLEN  word address (`i_addr`, registered).
- `o_bus_wdata`  out  XLEN  write data.
- `i_bus_ack`  in  1  transfer complete.
- `i_bus_rdata`  in  XLEN  read data, valid with ack.
- `i_bus_err`  in  1  bus fault, valid with ack.
- `i_inval`  in  1  an external store was observed.
- `i_inval_addr`  in  XLEN  address of that external store.

## Operation
- States: IDLE, READ, WRITE, DONE.
- **Acceptance.** In IDLE, when `i_start=1`, the block latches `i_op`, `i_addr` and `i_rs2`.
- **Misaligned or illegal op.** If `i_addr[1:0]!=0` or `i_op` is not a listed encoding, go to DONE with the error flag set. No bus access is made.
- **LR.** Go to READ. On ack, `o_rd` = rdata and the reservation is set to `{valid=1, addr granule}`. Then go to DONE.
- **SC, reservation check.** At acceptance, compare the reservation against the SC address granule.
  - Hit: go to WRITE with wdata = rs2, then DONE with `o_rd`=0.
  - Miss: go to DONE with `o_rd`=1 and no bus access.
  - Every SC clears the reservation at acceptance.
- **AMO.** Go to READ. On ack, latch rdata, set `o_rd` = rdata (the old value), and go to WRITE.
  - Write data is registered: `atomic_alu(op, s1=rs2, s2=rdata)`.
  - WRITE ack goes to DONE.
  - An AMO to the reservation granule clears the reservation at acceptance.
- **Bus handshake.**
  - `o_bus_req` and all `o_bus_*` signals are registered and held stable until a cycle with `i_bus_ack=1`.
  - `o_bus_req` deasserts on the cycle after the ack, unless the next state issues another request. In that case it stays high with the new addr/we/wdata.
  - Ack is permitted in the first cycle of the request. Wait states are unbounded.
- **Bus error.** `i_bus_err=1` with ack in READ or WRITE: go to DONE with the error flag set, skip any remaining phase, and clear the reservation.
- **DONE.** Pulse `o_done` (and `o_err` when applicable), then return to IDLE.
- **Invalidation.**
  - When `i_inval=1` and `i_inval_addr[XLEN-1:RSV_GRAN_LOG2]` matches the reservation, clear the reservation.
  - If this coincides with an LR ack setting the same granule, invalidation wins and the reservation ends up clear.
  - An invalidation after an SC has been accepted does not change that SC's outcome.
- **Width.** All arithmetic is XLEN-bit and wraps. MIN/MAX are signed; MINU/MAXU are unsigned.

## Timing
- **Reset.** With `rst_n=0` at an edge:
  - state goes to IDLE;
  - `o_busy`, `o_done`, `o_err`, `o_bus_req`, `o_bus_we` and the reservation valid bit become 0;
  - `o_rd`, `o_bus_addr` and `o_bus_wdata` become 0.
- **Reset mid-transaction.** The outstanding bus transaction is abandoned. A late ack is ignored in IDLE.
- **`i_start` while busy** is ignored; there is no queueing.
- **Latencies with zero wait states.** Start is sampled at edge 0; `o_done` is high in the cycle after:
  - edge 3 for an AMO;
  - edge 2 for an LR or a successful SC;
  - edge 1 for a failed SC, misaligned access or illegal op.
  - Each bus wait cycle adds one.
- **Back-to-back operation.** A new `i_start` is accepted in the cycle `o_busy` returns to 0, which is the cycle after `o_done`.

## Test plan
- **AMOADD, positive wrap.** Memory 0x7FFFFFFF, rs2=1, zero-wait bus:
  - write of 0x80000000;
  - `o_rd`=0x7FFFFFFF;
  - `o_done` 3 cycles after start.
- **AMOMIN vs AMOMINU.** Memory 0xFFFFFFFF, rs2=5:
  - MIN writes 0xFFFFFFFF;
  - MINU writes 5;
  - both return `o_rd`=0xFFFFFFFF.
- **LR/SC pair.**
  - LR 0x100 then SC 0x100 with rs2=0xAB: write of 0xAB, `o_rd`=0.
  - A second SC: no bus request, `o_rd`=1.
- **Invalidation.**
  - LR 0x100, then `i_inval` at 0x102, then SC 0x100: fails with `o_rd`=1.
  - `i_inval` at 0x104 instead: SC succeeds.
- **Bus error on AMO read**, after 2 wait states: `o_done`+`o_err`, no write request, reservation cleared.
- **Misalignment and reset.**
  - Address 0x101: `o_err` at edge 1 with no request.
  - `rst_n`=0 during WRITE wait: the next cycle has `o_bus_req`=0 and `o_busy`=0.
